sobel_frame_scheduler: RTL and testbench
========================================

Name: sobel_frame_scheduler

Overview:
Frame-level controller for the Sobel engine and its two frame BRAMs. It loads one frame from an input pixel stream into BRAM0 port 0, then kicks the engine in either MOVE (copy) or RUN (Sobel) mode and waits for completion. It then drains the result from BRAM1 port 0 to an output stream with backpressure. It sits between the pixel source/sink and the engine, and owns the BRAM ports the engine does not use.

Parameters:
DATA_WIDTH, 8, pixel width
ADDR_WIDTH, 16, BRAM address width
IMAGE_WIDTH, 100, pixels per line
IMAGE_HEIGHT, 100, lines per frame
TIMEOUT_CYCLES, 1000000, engine watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  asynchronous, active-high reset
i_start  in  1  one-cycle pulse; arms one frame; ignored unless state is IDLE
i_mode_run  in  1  sampled on an accepted i_start; 1 = RUN (Sobel), 0 = MOVE
s_valid  in  1  input pixel valid
s_data  in  DATA_WIDTH  input pixel
s_ready  out  1  input pixel ready
b0_ce0  out  1  BRAM0 port 0 chip enable
b0_we0  out  1  BRAM0 port 0 write enable
b0_addr0  out  ADDR_WIDTH  BRAM0 port 0 address
b0_d0  out  DATA_WIDTH  BRAM0 port 0 write data
o_eng_en  out  1  engine start pulse
o_eng_run  out  1  engine mode
o_eng_num_cnt  out  ADDR_WIDTH  pixel count presented to the engine
i_eng_idle  in  1  engine idle
i_eng_done  in  1  engine one-cycle done pulse
b1_ce0  out  1  BRAM1 port 0 chip enable (read only)
b1_addr0  out  ADDR_WIDTH  BRAM1 port 0 address
b1_q0  in  DATA_WIDTH  BRAM1 read data, valid 1 cycle after ce
m_valid  out  1  output pixel valid
m_data  out  DATA_WIDTH  output pixel
m_ready  in  1  output pixel ready
o_busy  out  1  state is not IDLE
o_frame_done  out  1  one-cycle pulse on the last output handshake
o_frame_cnt  out  8  completed frames, wraps 255 to 0
o_err  out  1  watchdog pulse (tied 0 without the optional feature)

Behaviour:
- States: IDLE, LOAD, KICK, WAIT, DRAIN.
- Reset values: state IDLE; all outputs 0; mode register 0; counters 0.
- IDLE: s_ready=0. An accepted i_start (i_start=1 and i_eng_idle=1) latches mode, clears addresses, and moves to LOAD. An i_start with i_eng_idle=0 is dropped.
- LOAD: s_ready=1.
  - Each s_valid&&s_ready writes BRAM0 the same cycle: b0_ce0=b0_we0=1, b0_addr0=load counter, b0_d0=s_data.
  - The counter increments per beat.
  - The beat with counter = IMAGE_WIDTH*IMAGE_HEIGHT-1 moves to KICK; s_ready drops the next cycle.
- KICK: 1 cycle. o_eng_en=1, o_eng_num_cnt=IMAGE_WIDTH*IMAGE_HEIGHT. Next state is WAIT.
- o_eng_run: equals the latched mode from KICK through the end of WAIT; 0 otherwise.
- WAIT: the first i_eng_done=1 moves to DRAIN. i_eng_done outside WAIT is ignored.
- DRAIN length N: IMAGE_WIDTH*IMAGE_HEIGHT in MOVE; (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) in RUN. Addresses run 0..N-1.
- DRAIN read issue:
  - A BRAM1 read (b1_ce0=1, b1_addr0=read counter) is issued when read counter < N and (buffer occupancy + reads in flight) < 2.
  - Data lands in a 2-entry output buffer the next cycle.
  - Reads stop when no buffer space remains, so no data is ever lost.
- DRAIN output: m_valid = buffer not empty; m_data = buffer head.
- Sustained throughput: 1 pixel/cycle while m_ready=1. First m_valid appears 2 cycles after DRAIN entry.
- Frame end: the N-th m_valid&&m_ready pulses o_frame_done, increments o_frame_cnt, and returns to IDLE. The buffer is empty at this point.
- Simultaneous events: i_start during LOAD/KICK/WAIT/DRAIN is ignored. m_ready held 0 stalls DRAIN indefinitely with m_data stable.
- Reset mid-frame: the block returns to IDLE immediately and the buffer is flushed. The engine is not reset by this block. The next i_start waits for i_eng_idle.
- Width rules: all counters are ADDR_WIDTH. IMAGE_WIDTH*IMAGE_HEIGHT must be ≤ 2^ADDR_WIDTH; elaboration fails via a generate-time check otherwise.

Optional Feature:
SOBEL_SCHED_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WAIT.
  - Reaching TIMEOUT_CYCLES without i_eng_done pulses o_err for 1 cycle and returns to IDLE.
  - o_frame_cnt is unchanged and no drain occurs.
- Undefined: no counter; WAIT has no exit other than i_eng_done; o_err is tied 0.

Decomposition:
- Shared package holds the state encoding (IDLE/LOAD/KICK/WAIT/DRAIN) and the derived localparams FRAME_PIX and RUN_PIX.
- One sub-module, sobel_out_skid: 2-entry FIFO with push, pop, count, and head data. The scheduler uses count for read credit.

Test Plan (W=4, H=4):
- MOVE frame: i_start, i_mode_run=0, 16 pixels 0x00..0x0F → KICK shows o_eng_num_cnt=16, o_eng_run=0. Engine model pulses done → 16 outputs read from BRAM1 addr 0..15 in order; o_frame_done at the 16th beat; o_frame_cnt=1.
- RUN frame: i_mode_run=1 → o_eng_run=1 through WAIT; exactly 4 outputs (addr 0..3), then IDLE.
- Backpressure: m_ready toggling 1,0,0,1 during DRAIN → no drop or duplication; m_data held while stalled; never more than 2 reads outstanding plus buffered.
- Ignored starts: i_start during LOAD is ignored; i_start with i_eng_idle=0 in IDLE leaves o_busy=0; s_valid in IDLE gets s_ready=0 and nothing is written.
- Reset mid-DRAIN after 2 beats → all outputs 0 next edge; a new frame then completes with o_frame_cnt=1 (MOVE).
- Watchdog (macro defined, TIMEOUT_CYCLES=50): no done pulse → o_err pulse at WAIT cycle 50, IDLE, o_frame_cnt unchanged.

Source files
------------

// File: rtl/sobel_frame_scheduler_pkg.sv
// Shared types and geometry helpers for the Sobel frame scheduler.
package sobel_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  // Pixel counts for a full frame and for the Sobel result, which loses the 1-pixel border
  function automatic int frame_pix(input int w, input int h);
    return w * h;
  endfunction

  function automatic int run_pix(input int w, input int h);
    return (w - 2) * (h - 2);
  endfunction

endpackage

// File: rtl/sobel_frame_scheduler_if.sv
// Pixel streams, BRAM ports and engine handshake of the Sobel frame scheduler.
interface sobel_frame_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  i_start, i_mode_run;
  logic                  s_valid, s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  b0_ce0, b0_we0;
  logic [ADDR_WIDTH-1:0] b0_addr0;
  logic [DATA_WIDTH-1:0] b0_d0;
  logic                  o_eng_en, o_eng_run;
  logic [ADDR_WIDTH-1:0] o_eng_num_cnt;
  logic                  i_eng_idle, i_eng_done;
  logic                  b1_ce0;
  logic [ADDR_WIDTH-1:0] b1_addr0;
  logic [DATA_WIDTH-1:0] b1_q0;
  logic                  m_valid, m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  o_busy, o_frame_done, o_err;
  logic [7:0]            o_frame_cnt;

  modport master (
    input  i_start, i_mode_run, s_valid, s_data, i_eng_idle, i_eng_done, b1_q0, m_ready,
    output s_ready, b0_ce0, b0_we0, b0_addr0, b0_d0, o_eng_en, o_eng_run, o_eng_num_cnt,
           b1_ce0, b1_addr0, m_valid, m_data, o_busy, o_frame_done, o_frame_cnt, o_err
  );

  modport slave (
    output i_start, i_mode_run, s_valid, s_data, i_eng_idle, i_eng_done, b1_q0, m_ready,
    input  s_ready, b0_ce0, b0_we0, b0_addr0, b0_d0, o_eng_en, o_eng_run, o_eng_num_cnt,
           b1_ce0, b1_addr0, m_valid, m_data, o_busy, o_frame_done, o_frame_cnt, o_err
  );
endinterface

// File: rtl/sobel_frame_scheduler_out_skid.sv
// Two-entry output FIFO between the BRAM1 read port and the output stream.
module sobel_out_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);
  logic [1:0][DATA_WIDTH-1:0] mem;
  logic                       wp, rp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rp];
endmodule

// File: rtl/sobel_frame_scheduler.sv
// Frame controller: load BRAM0, kick the Sobel engine, drain BRAM1 to the output stream.
// Optional engine watchdog enabled by defining SOBEL_SCHED_TIMEOUT_EN.
module sobel_frame_scheduler
  import sobel_frame_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int IMAGE_WIDTH    = 100,
  parameter int IMAGE_HEIGHT   = 100,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                    clk,
  input logic                    rst,
  sobel_frame_scheduler_if.master bus
);
  localparam int FRAME_PIX = frame_pix(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int RUN_PIX   = run_pix(IMAGE_WIDTH, IMAGE_HEIGHT);

  if (longint'(FRAME_PIX) > (longint'(1) << ADDR_WIDTH)) begin : g_size_chk
    $error("IMAGE_WIDTH*IMAGE_HEIGHT exceeds the BRAM address space");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_to_chk
    $error("TIMEOUT_CYCLES must be positive");
  end

  state_t                state;
  logic                  mode, rd_all, rd_pend;
  logic [ADDR_WIDTH-1:0] ld_cnt, rd_cnt, out_cnt, drain_last;
  logic [7:0]            frame_cnt;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  load_beat, hs, rd_issue, last_hs;

  assign drain_last = mode ? ADDR_WIDTH'(RUN_PIX - 1) : ADDR_WIDTH'(FRAME_PIX - 1);
  assign load_beat  = (state == ST_LOAD) && bus.s_valid;
  assign hs         = (occ != 2'd0) && bus.m_ready;
  assign last_hs    = (state == ST_DRAIN) && hs && (out_cnt == drain_last);
  // Credit counts the entry popped this cycle as free, which keeps 1 pixel/cycle with only 2 slots
  assign rd_issue   = (state == ST_DRAIN) && !rd_all &&
                      (({1'b0, occ} + {2'b0, rd_pend} - {2'b0, hs}) < 3'd2);

`ifdef SOBEL_SCHED_TIMEOUT_EN
  logic [31:0] wd;
  logic        err;
  assign bus.o_err = err;
`else
  assign bus.o_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode      <= 1'b0;
      ld_cnt    <= '0;
      rd_cnt    <= '0;
      out_cnt   <= '0;
      rd_all    <= 1'b0;
      rd_pend   <= 1'b0;
      frame_cnt <= '0;
`ifdef SOBEL_SCHED_TIMEOUT_EN
      wd        <= '0;
      err       <= 1'b0;
`endif
    end else begin
      rd_pend <= rd_issue;
`ifdef SOBEL_SCHED_TIMEOUT_EN
      err     <= 1'b0;
`endif
      case (state)
        ST_IDLE: if (bus.i_start && bus.i_eng_idle) begin
          mode    <= bus.i_mode_run;
          ld_cnt  <= '0;
          rd_cnt  <= '0;
          out_cnt <= '0;
          rd_all  <= 1'b0;
          state   <= ST_LOAD;
        end
        ST_LOAD: if (load_beat) begin
          ld_cnt <= ld_cnt + 1'b1;
          if (ld_cnt == ADDR_WIDTH'(FRAME_PIX - 1)) state <= ST_KICK;
        end
        ST_KICK: begin
          state <= ST_WAIT;
`ifdef SOBEL_SCHED_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        ST_WAIT: begin
          if (bus.i_eng_done) state <= ST_DRAIN;
`ifdef SOBEL_SCHED_TIMEOUT_EN
          else if (wd == 32'(TIMEOUT_CYCLES - 1)) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else wd <= wd + 1'b1;
`endif
        end
        ST_DRAIN: begin
          if (rd_issue) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == drain_last) rd_all <= 1'b1;
          end
          if (hs) out_cnt <= out_cnt + 1'b1;
          if (last_hs) begin
            frame_cnt <= frame_cnt + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sobel_out_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend),
    .push_data (bus.b1_q0),
    .pop       (hs),
    .count     (occ),
    .head      (head)
  );

  assign bus.s_ready       = (state == ST_LOAD);
  assign bus.b0_ce0        = load_beat;
  assign bus.b0_we0        = load_beat;
  assign bus.b0_addr0      = load_beat ? ld_cnt : '0;
  assign bus.b0_d0         = load_beat ? bus.s_data : '0;
  assign bus.o_eng_en      = (state == ST_KICK);
  assign bus.o_eng_run     = mode && ((state == ST_KICK) || (state == ST_WAIT));
  assign bus.o_eng_num_cnt = (state == ST_KICK) ? ADDR_WIDTH'(FRAME_PIX) : '0;
  assign bus.b1_ce0        = rd_issue;
  assign bus.b1_addr0      = rd_issue ? rd_cnt : '0;
  assign bus.m_valid       = (occ != 2'd0);
  assign bus.m_data        = head;
  assign bus.o_busy        = (state != ST_IDLE);
  assign bus.o_frame_done  = last_hs;
  assign bus.o_frame_cnt   = frame_cnt;
endmodule

// File: tb/tb_sobel_frame_scheduler.sv
module tb_sobel_frame_scheduler;
  localparam int DW = 8, AW = 16, W = 4, H = 4, TO = 50;
  localparam int FRAME_N = W * H;
  localparam int RUN_N   = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_frame_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  sobel_frame_scheduler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0, failures = 0, exp_fc = 0;
  logic [DW-1:0] bram1 [0:255];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) if (bus.b1_ce0) bus.b1_q0 <= bram1[bus.b1_addr0[7:0]];

  function automatic logic [81:0] outs();
    return {bus.s_ready, bus.b0_ce0, bus.b0_we0, bus.b0_addr0, bus.b0_d0, bus.o_eng_en,
            bus.o_eng_run, bus.o_eng_num_cnt, bus.b1_ce0, bus.b1_addr0, bus.m_valid,
            bus.m_data, bus.o_busy, bus.o_frame_done, bus.o_frame_cnt, bus.o_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit run, input bit seq_pix, input int bp, input int abort_after,
                       input bit hang);
    int n = run ? RUN_N : FRAME_N;
    int issued = 0, got = 0, cyc = 0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0, pix;
    bus.i_start = 1'b1; bus.i_mode_run = run; bus.i_eng_idle = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int i = 0; i < FRAME_N; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0; bus.i_start = 1'b1;
        @(negedge clk);
        chk("load_bubble_ce", bus.b0_ce0, 1'b0);
        chk("load_bubble_rdy", bus.s_ready, 1'b1);
        step();
        bus.i_start = 1'b0;
      end
      pix = seq_pix ? DW'(i) : DW'($urandom);
      bus.s_valid = 1'b1; bus.s_data = pix;
      @(negedge clk);
      chk("load_rdy", bus.s_ready, 1'b1);
      chk("load_we", {bus.b0_ce0, bus.b0_we0}, 2'b11);
      chk("load_addr", bus.b0_addr0, AW'(i));
      chk("load_d", bus.b0_d0, pix);
      step();
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("kick_en", bus.o_eng_en, 1'b1);
    chk("kick_num", bus.o_eng_num_cnt, AW'(FRAME_N));
    chk("kick_run", bus.o_eng_run, run);
    chk("kick_rdy", bus.s_ready, 1'b0);
    for (int i = 0; i < 256; i++) bram1[i] = DW'($urandom);
    bus.i_eng_idle = 1'b0;
    step();
`ifdef SOBEL_SCHED_TIMEOUT_EN
    if (hang) begin
      for (int k = 0; k <= TO + 1; k++) begin
        @(negedge clk);
        chk("wd_err", bus.o_err, (k == TO));
        chk("wd_busy", bus.o_busy, (k < TO));
        step();
      end
      chk("wd_fcnt", bus.o_frame_cnt, 8'(exp_fc));
      chk("wd_mvalid", bus.m_valid, 1'b0);
      bus.i_eng_idle = 1'b1;
      return;
    end
`endif
    repeat ($urandom_range(1, 5)) begin
      @(negedge clk);
      chk("wait_run", bus.o_eng_run, run);
      chk("wait_en", bus.o_eng_en, 1'b0);
      chk("wait_err", bus.o_err, 1'b0);
      step();
    end
    bus.i_eng_done = 1'b1;
    step();
    bus.i_eng_done = 1'b0; bus.i_eng_idle = 1'b1;
    while (got < n && cyc < 300) begin
      bus.m_ready = (bp == 0) ? 1'b1 : (bp == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3))
                                                  : 1'($urandom);
      @(negedge clk);
      if (cyc == 0) chk("drain_run", bus.o_eng_run, 1'b0);
      if (cyc < 2) chk("drain_early_v", bus.m_valid, 1'b0);
      if (cyc == 2) chk("drain_first_v", bus.m_valid, 1'b1);
      if (prev_stall) chk("stall_hold", {bus.m_valid, bus.m_data}, {1'b1, prev_d});
      if (bus.b1_ce0) begin
        chk("rd_addr", bus.b1_addr0, AW'(issued));
        issued++;
      end
      if (bus.m_valid) chk("out_data", bus.m_data, bram1[got]);
      if (bus.m_valid && bus.m_ready) begin
        chk("frame_done", bus.o_frame_done, (got == n - 1));
        got++;
      end
      chk("outstanding", (issued - got <= 2), 1'b1);
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_d     = bus.m_data;
      if (abort_after > 0 && got == abort_after) begin
        rst = 1'b1;
        #1;
        chk("abort_outs", outs(), 82'd0);
        bus.m_ready = 1'b0;
        step();
        rst = 1'b0; exp_fc = 0;
        return;
      end
      step();
      cyc++;
    end
    chk("drain_count", got, n);
    if (bp == 0) chk("throughput", cyc, n + 2);
    exp_fc = (exp_fc + 1) % 256;
    bus.m_ready = 1'b0;
    @(negedge clk);
    chk("end_busy", bus.o_busy, 1'b0);
    chk("end_fcnt", bus.o_frame_cnt, 8'(exp_fc));
    chk("end_done", bus.o_frame_done, 1'b0);
    chk("end_issued", issued, n);
    step();
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_mode_run = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    bus.i_eng_idle = 1'b1; bus.i_eng_done = 1'b0; bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), 82'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", outs(), 82'd0);
    step();

    bus.i_eng_idle = 1'b0; bus.i_start = 1'b1; bus.s_valid = 1'b1; bus.s_data = 8'hAA;
    bus.i_eng_done = 1'b1;
    @(negedge clk);
    chk("idle_rdy", bus.s_ready, 1'b0);
    chk("idle_ce", bus.b0_ce0, 1'b0);
    step();
    bus.i_start = 1'b0; bus.s_valid = 1'b0; bus.i_eng_done = 1'b0;
    @(negedge clk);
    chk("busy_drop", bus.o_busy, 1'b0);
    chk("idle_outs", outs(), 82'd0);
    step();

    frame(1'b0, 1'b1, 0, 0, 1'b0);
    frame(1'b1, 1'b0, 0, 0, 1'b0);
    frame(1'b0, 1'b0, 1, 0, 1'b0);
    frame(1'b1, 1'b0, 2, 0, 1'b0);
    frame(1'b0, 1'b0, 2, 0, 1'b0);
    frame(1'b0, 1'b0, 0, 2, 1'b0);
    frame(1'b0, 1'b1, 0, 0, 1'b0);
    chk("fcnt_after_abort", bus.o_frame_cnt, 8'd1);
`ifdef SOBEL_SCHED_TIMEOUT_EN
    frame(1'b1, 1'b0, 0, 0, 1'b1);
    frame(1'b1, 1'b0, 0, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
